// File: rtl/mac_rx_fcs_check.sv
// Receive framing/integrity stage: strips preamble/SFD, forwards DA..payload with the
// FCS held back by a 4-byte delay line, and reports CRC/length/PHY/address status per frame.
module mac_rx_fcs_check #(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter bit          PROMISC   = 1'b0,
  parameter int          MIN_LEN   = 64,
  parameter int          MAX_LEN   = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_dv,
  input  logic        rx_err,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_sof,
  output logic        frame_done,
  output logic        frame_good,
  output logic        crc_err,
  output logic        len_err,
  output logic        phy_err,
  output logic        addr_miss,
  output logic [10:0] frame_len,
  output logic [15:0] ok_cnt,
  output logic [15:0] bad_cnt
);

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L       = 11'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_BODY, S_DROP} state_t;

  state_t          state, state_nx;
  logic [3:0]      pre_cnt;
  logic [31:0]     crc;
  logic [10:0]     len;
  logic            phy_seen;
  logic [3:0][7:0] dly;
  logic [47:0]     da;
  logic            body_byte, body_end;
  logic            st_crc, st_len, st_miss, st_bad;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // A preamble run of 15 bytes is treated as garbage rather than waiting forever for SFD.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (rx_dv) state_nx = (rx_data == 8'h55) ? S_PREAMBLE : S_DROP;
      S_PREAMBLE: begin
        if (!rx_dv)                                      state_nx = S_IDLE;
        else if (rx_err)                                 state_nx = S_DROP;
        else if (rx_data == 8'hD5)                       state_nx = S_BODY;
        else if (rx_data == 8'h55 && pre_cnt != 4'd14)   state_nx = S_PREAMBLE;
        else                                             state_nx = S_DROP;
      end
      S_BODY:     if (!rx_dv) state_nx = S_IDLE;
      S_DROP:     if (!rx_dv) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  assign body_byte = (state == S_BODY) && rx_dv;
  assign body_end  = (state == S_BODY) && !rx_dv;

  assign st_crc  = (crc != CRC_RESIDUE);
  assign st_len  = (len < MIN_L) || (len > MAX_L);
  assign st_miss = (len < 11'd6) ||
                   !((PROMISC != 1'b0) || (da == LOCAL_MAC) || (da == '1) || da[40]);
  assign st_bad  = st_crc | st_len | phy_seen | st_miss;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt    <= '0;
      crc        <= '0;
      len        <= '0;
      phy_seen   <= 1'b0;
      dly        <= '0;
      da         <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_sof      <= 1'b0;
      frame_done <= 1'b0;
      frame_good <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      phy_err    <= 1'b0;
      addr_miss  <= 1'b0;
      frame_len  <= '0;
      ok_cnt     <= '0;
      bad_cnt    <= '0;
    end else begin
      m_valid    <= 1'b0;
      m_sof      <= 1'b0;
      frame_done <= 1'b0;

      if (state == S_IDLE && rx_dv)     pre_cnt <= 4'd1;
      if (state == S_PREAMBLE && rx_dv) pre_cnt <= pre_cnt + 4'd1;

      if (state == S_PREAMBLE && state_nx == S_BODY) begin
        crc      <= 32'hFFFF_FFFF;
        len      <= '0;
        phy_seen <= 1'b0;
      end

      if (body_byte) begin
        crc <= crc_next(crc, rx_data);
        if (len != 11'h7FF) len <= len + 11'd1;
        if (rx_err)         phy_seen <= 1'b1;
        dly <= {dly[2:0], rx_data};
        if (len < 11'd6)    da <= {da[39:0], rx_data};
        // Emit only once four bytes are buffered, so the trailing FCS never leaves.
        if (len >= 11'd4) begin
          m_data  <= dly[3];
          m_valid <= 1'b1;
          m_sof   <= (len == 11'd4);
        end
      end

      if (body_end) begin
        frame_done <= 1'b1;
        frame_good <= !st_bad;
        crc_err    <= st_crc;
        len_err    <= st_len;
        phy_err    <= phy_seen;
        addr_miss  <= st_miss;
        frame_len  <= len;
        if (st_bad) begin
          if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
        end else begin
          if (ok_cnt != 16'hFFFF)  ok_cnt <= ok_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_rx_fcs_check.sv
// Directed bench for mac_rx_fcs_check: frame-level scoreboard (expected bytes and
// status per frame) checked every cycle, plus literal expectations per scenario.
module tb_mac_rx_fcs_check;

  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [7:0] d; logic sof; } dexp_t;
  typedef struct { bit good, crc, len, phy, miss; int flen, ok, bad; } sexp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_dv = 1'b0, rx_err = 1'b0;

  logic [7:0]  m_data;
  logic        m_valid, m_sof, frame_done, frame_good, crc_err, len_err, phy_err, addr_miss;
  logic [10:0] frame_len;
  logic [15:0] ok_cnt, bad_cnt;

  logic [7:0]  p_m_data;
  logic        p_m_valid, p_m_sof, p_frame_done, p_frame_good, p_crc_err, p_len_err, p_phy_err, p_addr_miss;
  logic [10:0] p_frame_len;
  logic [15:0] p_ok_cnt, p_bad_cnt;

  always #5 clk = ~clk;

  mac_rx_fcs_check #(.LOCAL_MAC(LOCAL), .PROMISC(1'b0), .MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_dv(rx_dv), .rx_err(rx_err),
    .m_data(m_data), .m_valid(m_valid), .m_sof(m_sof), .frame_done(frame_done),
    .frame_good(frame_good), .crc_err(crc_err), .len_err(len_err), .phy_err(phy_err),
    .addr_miss(addr_miss), .frame_len(frame_len), .ok_cnt(ok_cnt), .bad_cnt(bad_cnt));

  mac_rx_fcs_check #(.LOCAL_MAC(LOCAL), .PROMISC(1'b1), .MIN_LEN(64), .MAX_LEN(1518)) dut_p (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_dv(rx_dv), .rx_err(rx_err),
    .m_data(p_m_data), .m_valid(p_m_valid), .m_sof(p_m_sof), .frame_done(p_frame_done),
    .frame_good(p_frame_good), .crc_err(p_crc_err), .len_err(p_len_err), .phy_err(p_phy_err),
    .addr_miss(p_addr_miss), .frame_len(p_frame_len), .ok_cnt(p_ok_cnt), .bad_cnt(p_bad_cnt));

  int n_tests = 0, n_fail = 0;
  int cyc = 0, t_mark = 0, vcount = 0;
  int ok_m = 0, bad_m = 0;
  logic [7:0] first_byte = 8'h00;
  dexp_t dq[$];
  sexp_t sq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input bq_t b, input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++)
        c = (c[0] ^ b[i][k]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return ~c;
  endfunction

  // DA, SA 02:00:00:00:00:02, type 0x0800, patterned payload, FCS little-endian.
  function automatic bq_t build(input logic [47:0] da, input int n);
    bq_t f;
    logic [31:0] fcs;
    f = {};
    for (int i = 0; i < 6; i++) f.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 5; i++) f.push_back(i == 0 ? 8'h02 : 8'h00);
    f.push_back(8'h02);
    f.push_back(8'h08);
    f.push_back(8'h00);
    while (f.size() < n - 4) f.push_back(8'(f.size() * 7 + 1));
    fcs = crc32(f, f.size());
    for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
    return f;
  endfunction

  task automatic expect_frame(input bq_t b, input bit phy);
    int n;
    logic [47:0] da;
    logic [31:0] fcs;
    sexp_t s;
    n = b.size();
    da = '0;
    fcs = '0;
    for (int i = 0; i < n - 4; i++) dq.push_back('{b[i], (i == 0)});
    s.flen = (n > 2047) ? 2047 : n;
    if (n >= 4) fcs = {b[n-1], b[n-2], b[n-3], b[n-4]};
    s.crc = (n < 4) || (fcs != crc32(b, n - 4));
    s.len = (n < 64) || (n > 1518);
    s.phy = phy;
    if (n >= 6) da = {b[0], b[1], b[2], b[3], b[4], b[5]};
    s.miss = (n < 6) || !((da == LOCAL) || (da == '1) || da[40]);
    s.good = !(s.crc || s.len || s.phy || s.miss);
    if (s.good) ok_m++; else bad_m++;
    s.ok = ok_m;
    s.bad = bad_m;
    sq.push_back(s);
  endtask

  task automatic drive(input bq_t w, input int err_at);
    for (int i = 0; i < w.size(); i++) begin
      @(posedge clk); #1;
      rx_dv = 1'b1; rx_data = w[i]; rx_err = (i == err_at);
      if (i == 8) t_mark = cyc;
    end
    @(posedge clk); #1;
    rx_dv = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic bq_t with_preamble(input bq_t b);
    bq_t w;
    w = {};
    for (int i = 0; i < 7; i++) w.push_back(8'h55);
    w.push_back(8'hD5);
    foreach (b[i]) w.push_back(b[i]);
    return w;
  endfunction

  task automatic send(input bq_t b, input int err_at);
    expect_frame(b, (err_at >= 0) && (err_at < b.size()));
    vcount = 0;
    drive(with_preamble(b), (err_at >= 0) ? err_at + 8 : -1);
  endtask

  always @(negedge clk) begin
    dexp_t e;
    sexp_t s;
    if (m_valid === 1'b1) begin
      vcount++;
      if (dq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_data: got %0h expected no output", m_data);
      end else begin
        e = dq.pop_front();
        check("m_data", m_data, e.d);
        check("m_sof", m_sof, e.sof);
        if (e.sof) begin
          first_byte = m_data;
          check("sof_latency", cyc - t_mark, 5);
        end
      end
    end else if (m_sof !== 1'b0) begin
      check("sof_without_valid", m_sof, 0);
    end
    if (frame_done === 1'b1) begin
      check("done_with_valid", m_valid, 0);
      if (sq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_done: got frame_done expected none");
      end else begin
        s = sq.pop_front();
        check("frame_good", frame_good, s.good);
        check("crc_err", crc_err, s.crc);
        check("len_err", len_err, s.len);
        check("phy_err", phy_err, s.phy);
        check("addr_miss", addr_miss, s.miss);
        check("frame_len", frame_len, s.flen);
        check("ok_cnt", ok_cnt, s.ok);
        check("bad_cnt", bad_cnt, s.bad);
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_sof"}, m_sof, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_good"}, frame_good, 0);
    check({tag, "_flags"}, {crc_err, len_err, phy_err, addr_miss}, 0);
    check({tag, "_len"}, frame_len, 0);
    check({tag, "_ok"}, ok_cnt, 0);
    check({tag, "_bad"}, bad_cnt, 0);
  endtask

  initial begin
    bq_t b, w, pin;
    string s9;

    s9 = "123456789";
    pin = {};
    for (int i = 0; i < 9; i++) pin.push_back(s9[i]);
    check("model_crc32_pin", crc32(pin, 9), 32'hCBF43926);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // minimum good frame
    b = build(LOCAL, 64);
    send(b, -1);
    check("min_good", frame_good, 1);
    check("min_len", frame_len, 64);
    check("min_ok", ok_cnt, 1);
    check("min_bad", bad_cnt, 0);
    check("min_bytes", vcount, 60);
    check("min_first", first_byte, 8'h02);

    // one payload bit flipped
    b = build(LOCAL, 64);
    b[20] = b[20] ^ 8'h10;
    send(b, -1);
    check("crc_flag", crc_err, 1);
    check("crc_good", frame_good, 0);
    check("crc_bad", bad_cnt, 1);
    check("crc_bytes", vcount, 60);

    // runt and oversize
    send(build(LOCAL, 20), -1);
    check("runt_len_err", len_err, 1);
    check("runt_crc", crc_err, 0);
    check("runt_len", frame_len, 20);
    check("runt_bytes", vcount, 16);
    send(build(LOCAL, 1519), -1);
    check("big_len_err", len_err, 1);
    check("big_len", frame_len, 1519);

    // PHY error in body, then in preamble
    send(build(LOCAL, 100), 30);
    check("phy_flag", phy_err, 1);
    check("phy_bad", bad_cnt, 4);
    vcount = 0;
    drive(with_preamble(build(LOCAL, 64)), 2);
    check("pre_err_bytes", vcount, 0);
    check("pre_err_ok", ok_cnt, 1);
    check("pre_err_bad", bad_cnt, 4);

    // address filter
    send(build(48'h02_00_00_00_00_99, 64), -1);
    check("miss_flag", addr_miss, 1);
    check("miss_good", frame_good, 0);
    check("promisc_good", p_frame_good, 1);
    check("promisc_miss", p_addr_miss, 0);
    send(build(48'hFF_FF_FF_FF_FF_FF, 64), -1);
    check("bcast_good", frame_good, 1);
    send(build(48'h01_00_5E_00_00_01, 80), -1);
    check("mcast_good", frame_good, 1);

    // bad preamble byte drops the whole burst
    w = {8'h55, 8'h00};
    for (int i = 0; i < 20; i++) w.push_back(8'hA0);
    vcount = 0;
    drive(w, -1);
    check("drop_bytes", vcount, 0);
    check("drop_ok", ok_cnt, 3);
    check("drop_bad", bad_cnt, 5);

    // 3-byte body: status only
    b = build(LOCAL, 64);
    w = {b[0], b[1], b[2]};
    send(w, -1);
    check("short_len_err", len_err, 1);
    check("short_len", frame_len, 3);
    check("short_bytes", vcount, 0);
    check("short_bad", bad_cnt, 6);

    // reset mid-frame, released while rx_dv still high on 0x3C
    b = build(LOCAL, 64);
    w = with_preamble(b);
    for (int i = 0; i < 6; i++) dq.push_back('{b[i], (i == 0)});
    vcount = 0;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      rx_dv = 1'b1; rx_data = w[i]; rx_err = 1'b0;
      if (i == 8) t_mark = cyc;
    end
    @(posedge clk); #1;
    rst = 1'b1; rx_data = 8'h3C;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ok_m = 0;
    bad_m = 0;
    repeat (4) begin
      @(negedge clk);
      check_idle_outputs("post_rst");
    end
    @(posedge clk); #1;
    rx_dv = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("cut_bytes", vcount, 6);
    send(build(LOCAL, 64), -1);
    check("resync_good", frame_good, 1);
    check("resync_ok", ok_cnt, 1);
    check("resync_bad", bad_cnt, 0);

    repeat (4) @(posedge clk);
    check("leftover_data", dq.size(), 0);
    check("leftover_status", sq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
